bus_rr_arbiter: RTL and testbench



---
 rtl/bus_rr_arbiter.sv | 110 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among NUM requesters,
// with a burst lock of up to MAX_BURST beats and a single output register stage.
module bus_rr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM       = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM-1:0]           valid_i,
  output logic [NUM-1:0]           ready_o,
  input  logic [NUM*WIDTH-1:0]     data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(NUM)-1:0]   grant_o
);
  localparam int IW = $clog2(NUM);
  localparam int CW = $clog2(MAX_BURST + 1);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [IW-1:0]    r_grant;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_owner;
  logic             r_own_vld;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_slice [NUM];
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_rr_sel;
  logic             w_rr_hit;
  logic             w_lock;
  logic [IW-1:0]    w_sel;
  logic             w_hit;
  logic             w_load;
  logic             w_xfer;
  logic [CW-1:0]    w_cnt_nxt;

  for (genvar g = 0; g < NUM; g++) begin : g_slice
    assign w_slice[g] = data_i[g*WIDTH +: WIDTH];
  end

  function automatic logic [IW-1:0] f_next(input logic [IW-1:0] x);
    return (x == IW'(NUM-1)) ? '0 : x + 1'b1;
  endfunction

  // Scan from the far end back toward ptr so the nearest valid index wins.
  always_comb begin
    w_idx    = '0;
    w_rr_sel = '0;
    w_rr_hit = 1'b0;
    for (int k = NUM-1; k >= 0; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % NUM);
      if (valid_i[w_idx]) begin
        w_rr_sel = w_idx;
        w_rr_hit = 1'b1;
      end
    end
  end

  assign w_lock    = r_own_vld && valid_i[r_owner] && (r_cnt < CW'(MAX_BURST));
  assign w_sel     = w_lock ? r_owner : w_rr_sel;
  assign w_hit     = w_lock || w_rr_hit;
  assign w_load    = !r_valid || ready_i;
  assign w_xfer    = rstn && w_load && w_hit;
  assign w_cnt_nxt = w_lock ? r_cnt + 1'b1 : CW'(1);

  always_comb begin
    ready_o = '0;
    if (w_xfer) ready_o[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_own_vld <= 1'b0;
      r_cnt     <= '0;
    end else if (w_load) begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_data  <= w_slice[w_sel];
        r_grant <= w_sel;
        r_owner <= w_sel;
        if (w_cnt_nxt == CW'(MAX_BURST)) begin
          r_own_vld <= 1'b0;
          r_cnt     <= '0;
          r_ptr     <= f_next(w_sel);
        end else begin
          r_own_vld <= 1'b1;
          r_cnt     <= w_cnt_nxt;
          if (!w_lock) r_ptr <= f_next(w_sel);
        end
      end else begin
        // Nothing selectable means the owner has dropped valid: release the lock.
        r_own_vld <= 1'b0;
        r_cnt     <= '0;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign grant_o = r_grant;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Table-driven bench for bus_rr_arbiter: per-cycle ready/valid expectations
// plus a beat scoreboard, and a MAX_BURST=1 instance for strict alternation.
module tb_bus_rr_arbiter;
  localparam int W = 32;
  localparam int N = 4;

  typedef struct {
    logic       rstn;
    logic [3:0] v;
    logic       rdy;
    logic [3:0] er;
    logic       evo;
  } vec_t;

  typedef struct {
    logic [1:0]  g;
    logic [31:0] d;
  } beat_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   valid_i, ready_o;
  logic [N*W-1:0] data_i;
  logic           valid_o, ready_i;
  logic [W-1:0]   data_o;
  logic [1:0]     grant_o;

  logic [N-1:0]   valid1, ready1_o;
  logic [N*W-1:0] data1;
  logic           vo1, rdy1;
  logic [W-1:0]   do1;
  logic [1:0]     g1;

  int n_vec = 0;
  int n_err = 0;
  vec_t  tbl[$];
  beat_t sb[$];
  int    seq [N];

  always #5 clk = ~clk;

  bus_rr_arbiter #(.WIDTH(W), .NUM(N), .MAX_BURST(4)) dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .grant_o(grant_o));

  bus_rr_arbiter #(.WIDTH(W), .NUM(N), .MAX_BURST(1)) dut1 (
    .clk(clk), .rstn(rstn), .valid_i(valid1), .ready_o(ready1_o), .data_i(data1),
    .valid_o(vo1), .ready_i(rdy1), .data_o(do1), .grant_o(g1));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] v, input logic rdy,
                              input logic [3:0] er, input logic evo);
    vec_t t;
    t.rstn = r; t.v = v; t.rdy = rdy; t.er = er; t.evo = evo;
    tbl.push_back(t);
  endfunction

  initial begin
    logic        prev_rst, prev_stall;
    logic [31:0] hold_d;
    logic [1:0]  hold_g;
    beat_t       b;
    logic [3:0]  exp1;
    logic [1:0]  last1;

    for (int i = 0; i < N; i++) seq[i] = 1;
    rstn = 1'b0; valid_i = '0; ready_i = 1'b1; data_i = '0;
    valid1 = '0; rdy1 = 1'b1;
    for (int i = 0; i < N; i++) data1[i*W +: W] = 32'h1111_1111 * i;
    @(negedge clk);

    // Reset with every requester valid.
    add(0, 4'b1111, 1, 4'b0000, 0);
    add(0, 4'b1111, 1, 4'b0000, 0);
    // All four valid: bursts of 4, rotating 0,1,2,3,0.
    for (int c = 0; c < 17; c++)
      add(1, 4'b1111, 1, 4'(1 << ((c / 4) % 4)), c != 0);
    add(0, 4'b0000, 0, 4'b0000, 1);
    // Lone requester 1: no bubble across the burst boundary.
    for (int c = 0; c < 6; c++) add(1, 4'b0010, 1, 4'b0010, c != 0);
    add(0, 4'b0000, 0, 4'b0000, 1);
    // Backpressure mid-burst of requester 2.
    add(1, 4'b1100, 1, 4'b0100, 0);
    add(1, 4'b1100, 1, 4'b0100, 1);
    for (int c = 0; c < 5; c++) add(1, 4'b1100, 0, 4'b0000, 1);
    add(1, 4'b1100, 1, 4'b0100, 1);
    add(1, 4'b1100, 1, 4'b0100, 1);
    add(1, 4'b1100, 1, 4'b1000, 1);
    add(1, 4'b1100, 1, 4'b1000, 1);
    add(0, 4'b0000, 0, 4'b0000, 1);
    // Owner drop, then reset while a beat is held.
    add(1, 4'b0101, 1, 4'b0001, 0);
    add(1, 4'b0101, 1, 4'b0001, 1);
    add(1, 4'b0100, 1, 4'b0100, 1);
    add(1, 4'b0100, 1, 4'b0100, 1);
    add(1, 4'b0100, 0, 4'b0000, 1);
    add(0, 4'b0100, 0, 4'b0000, 1);
    add(1, 4'b1010, 1, 4'b0010, 0);
    add(1, 4'b1010, 1, 4'b0010, 1);

    prev_rst = 1'b1; prev_stall = 1'b0; hold_d = '0; hold_g = '0;
    foreach (tbl[k]) begin
      @(negedge clk);
      rstn = tbl[k].rstn; valid_i = tbl[k].v; ready_i = tbl[k].rdy;
      for (int i = 0; i < N; i++) data_i[i*W +: W] = {8'(i), 24'(seq[i])};
      #1;
      if (prev_rst) begin
        chk($sformatf("rst_valid[%0d]", k), 64'(valid_o), 64'(0));
        chk($sformatf("rst_data[%0d]",  k), 64'(data_o),  64'(0));
        chk($sformatf("rst_grant[%0d]", k), 64'(grant_o), 64'(0));
      end
      if (prev_stall) begin
        chk($sformatf("hold_data[%0d]",  k), 64'(data_o),  64'(hold_d));
        chk($sformatf("hold_grant[%0d]", k), 64'(grant_o), 64'(hold_g));
      end
      chk($sformatf("ready_o[%0d]", k), 64'(ready_o), 64'(tbl[k].er));
      chk($sformatf("valid_o[%0d]", k), 64'(valid_o), 64'(tbl[k].evo));
      if (rstn) begin
        if (valid_o && ready_i) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL beat[%0d]: got unexpected beat %0h expected none", k, data_o);
          end else begin
            b = sb.pop_front();
            chk($sformatf("beat_grant[%0d]", k), 64'(grant_o), 64'(b.g));
            chk($sformatf("beat_data[%0d]",  k), 64'(data_o),  64'(b.d));
          end
        end
        for (int i = 0; i < N; i++)
          if (valid_i[i] && ready_o[i]) begin
            b.g = 2'(i); b.d = data_i[i*W +: W];
            sb.push_back(b);
            seq[i]++;
          end
      end else begin
        sb.delete();
        for (int i = 0; i < N; i++) seq[i] = 1;
      end
      prev_rst   = !rstn;
      prev_stall = rstn && valid_o && !ready_i;
      hold_d     = data_o;
      hold_g     = grant_o;
    end

    // MAX_BURST=1 instance: requesters 1 and 3 alternate every beat.
    exp1 = 4'b0010; last1 = 2'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rstn = 1'b1; valid_i = '0; valid1 = 4'b1010; rdy1 = 1'b1;
      #1;
      chk($sformatf("mb1_ready[%0d]", c), 64'(ready1_o), 64'(exp1));
      if (c > 0) begin
        chk($sformatf("mb1_grant[%0d]", c), 64'(g1), 64'(last1));
        chk($sformatf("mb1_data[%0d]",  c), 64'(do1), 64'(32'h1111_1111 * last1));
      end
      last1 = (exp1 == 4'b0010) ? 2'd1 : 2'd3;
      exp1  = (exp1 == 4'b0010) ? 4'b1000 : 4'b0010;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
